// File: rtl/virtio_mmio_regs_if.sv
// AXI4-Lite bus between the core and the virtio-mmio register block.
// The master drives addresses and write data; the slave answers with ready and response signals.
interface virtio_mmio_regs_if;
  logic [31:0] core_araddr;
  logic [2:0]  core_arprot;
  logic        core_arvalid;
  logic        core_arready;
  logic [31:0] core_rdata;
  logic [1:0]  core_rresp;
  logic        core_rvalid;
  logic        core_rready;
  logic [31:0] core_awaddr;
  logic [2:0]  core_awprot;
  logic        core_awvalid;
  logic        core_awready;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_wvalid;
  logic        core_wready;
  logic [1:0]  core_bresp;
  logic        core_bvalid;
  logic        core_bready;

  modport slave (
    input  core_araddr, core_arprot, core_arvalid, core_rready,
    input  core_awaddr, core_awprot, core_awvalid, core_wdata, core_wstrb, core_wvalid, core_bready,
    output core_arready, core_rdata, core_rresp, core_rvalid,
    output core_awready, core_wready, core_bresp, core_bvalid
  );

  modport master (
    output core_araddr, core_arprot, core_arvalid, core_rready,
    output core_awaddr, core_awprot, core_awvalid, core_wdata, core_wstrb, core_wvalid, core_bready,
    input  core_arready, core_rdata, core_rresp, core_rvalid,
    input  core_awready, core_wready, core_bresp, core_bvalid
  );
endinterface

// File: rtl/virtio_mmio_regs.sv
// virtio-mmio (v2) register front-end: an AXI4-Lite slave with per-queue configuration,
// notify and interrupt sideband towards the device backend, and a driver-initiated device reset.
module virtio_mmio_regs #(
  parameter int          NUM_QUEUES    = 1,
  parameter int          QUEUE_NUM_MAX = 8,
  parameter logic [31:0] DEVICE_ID     = 32'd2,
  parameter logic [31:0] VENDOR_ID     = 32'h554d4551,
  parameter logic [63:0] DEV_FEATURES  = 64'h0
) (
  input  logic                       clk,
  input  logic                       rstn,
  virtio_mmio_regs_if.slave          axi,
  output logic [NUM_QUEUES-1:0]      q_ready,
  output logic [16*NUM_QUEUES-1:0]   q_num,
  output logic [32*NUM_QUEUES-1:0]   q_desc,
  output logic [32*NUM_QUEUES-1:0]   q_avail,
  output logic [32*NUM_QUEUES-1:0]   q_used,
  output logic                       notify_valid,
  output logic [3:0]                 notify_queue,
  input  logic                       irq_used_set,
  input  logic                       irq_config_set,
  output logic                       dev_reset,
  output logic                       virtio_interrupt
);

  localparam logic [31:0] NQ_W  = 32'(NUM_QUEUES);
  localparam logic [31:0] QNM_W = 32'(QUEUE_NUM_MAX);

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;

  rd_state_t rd_state_reg, rd_state_next;
  wr_state_t wr_state_reg, wr_state_next;

  logic [31:0] rdata_reg;
  logic [31:0] rd_val;
  logic        ar_fire;
  logic        aw_fire;

  logic [31:0]      dev_feat_sel_reg;
  logic [31:0]      drv_feat_sel_reg;
  logic [1:0][31:0] drv_features_reg;
  logic [31:0]      queue_sel_reg;
  logic [7:0]       status_reg;
  logic [1:0]       int_status_reg;

  logic [NUM_QUEUES-1:0][15:0] q_num_reg;
  logic [NUM_QUEUES-1:0]       q_ready_reg;
  logic [NUM_QUEUES-1:0][31:0] q_desc_reg;
  logic [NUM_QUEUES-1:0][31:0] q_avail_reg;
  logic [NUM_QUEUES-1:0][31:0] q_used_reg;

  logic [NUM_QUEUES-1:0] sel_hit;
  logic                  sel_valid;
  logic [15:0]           sel_num;
  logic                  sel_ready;
  logic [31:0]           sel_desc;
  logic [31:0]           sel_avail;
  logic [31:0]           sel_used;

  logic [8:0]  rd_off;
  logic [8:0]  wr_off;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        status_clear;
  logic [1:0]  irq_ack;
  logic [1:0]  irq_set;
  logic        unused_ok;

  assign unused_ok = ^{axi.core_araddr[31:9], axi.core_awaddr[31:9], axi.core_arprot, axi.core_awprot};

  // ---------------- read channel ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_state_reg <= R_IDLE;
    else       rd_state_reg <= rd_state_next;
  end

  always_comb begin
    rd_state_next    = rd_state_reg;
    axi.core_arready = 1'b0;
    axi.core_rvalid  = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        axi.core_arready = 1'b1;
        if (axi.core_arvalid) rd_state_next = R_RESP;
      end
      R_RESP: begin
        axi.core_rvalid = 1'b1;
        if (axi.core_rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign ar_fire        = axi.core_arvalid && (rd_state_reg == R_IDLE);
  assign axi.core_rdata = rdata_reg;
  assign axi.core_rresp = 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        rdata_reg <= '0;
    else if (ar_fire) rdata_reg <= rd_val;
  end

  // ---------------- write channel ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wr_state_reg <= W_IDLE;
    else       wr_state_reg <= wr_state_next;
  end

  always_comb begin
    wr_state_next    = wr_state_reg;
    axi.core_awready = 1'b0;
    axi.core_wready  = 1'b0;
    axi.core_bvalid  = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        axi.core_awready = 1'b1;
        axi.core_wready  = 1'b1;
        if (axi.core_awvalid && axi.core_wvalid) wr_state_next = W_RESP;
      end
      W_RESP: begin
        axi.core_bvalid = 1'b1;
        if (axi.core_bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  assign aw_fire        = axi.core_awvalid && axi.core_wvalid && (wr_state_reg == W_IDLE);
  assign axi.core_bresp = 2'b00;

  // Partial-strobe writes are acknowledged but never touch register state.
  assign rd_off       = axi.core_araddr[8:0];
  assign wr_off       = axi.core_awaddr[8:0];
  assign wr_data      = axi.core_wdata;
  assign wr_en        = aw_fire && (axi.core_wstrb == 4'hf);
  assign status_clear = wr_en && (wr_off == 9'h070) && (wr_data[7:0] == 8'h00);
  assign irq_ack      = (wr_en && (wr_off == 9'h064)) ? wr_data[1:0] : 2'b00;
  assign irq_set      = {irq_config_set, irq_used_set};

  // ---------------- queue selection ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
      assign sel_hit[gi]            = (queue_sel_reg == 32'(gi));
      assign q_ready[gi]            = q_ready_reg[gi];
      assign q_num[gi*16 +: 16]     = q_num_reg[gi];
      assign q_desc[gi*32 +: 32]    = q_desc_reg[gi];
      assign q_avail[gi*32 +: 32]   = q_avail_reg[gi];
      assign q_used[gi*32 +: 32]    = q_used_reg[gi];
    end
  endgenerate

  assign sel_valid = |sel_hit;

  always_comb begin
    sel_num   = '0;
    sel_ready = 1'b0;
    sel_desc  = '0;
    sel_avail = '0;
    sel_used  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (sel_hit[i]) begin
        sel_num   = q_num_reg[i];
        sel_ready = q_ready_reg[i];
        sel_desc  = q_desc_reg[i];
        sel_avail = q_avail_reg[i];
        sel_used  = q_used_reg[i];
      end
    end
  end

  // ---------------- read decode ----------------
  always_comb begin
    rd_val = '0;
    case (rd_off)
      9'h000: rd_val = 32'h74726976;
      9'h004: rd_val = 32'd2;
      9'h008: rd_val = DEVICE_ID;
      9'h00c: rd_val = VENDOR_ID;
      9'h010: begin
        if (dev_feat_sel_reg == 32'd0)      rd_val = DEV_FEATURES[31:0];
        else if (dev_feat_sel_reg == 32'd1) rd_val = DEV_FEATURES[63:32];
      end
      9'h020: begin
        if (drv_feat_sel_reg == 32'd0)      rd_val = drv_features_reg[0];
        else if (drv_feat_sel_reg == 32'd1) rd_val = drv_features_reg[1];
      end
      9'h030: rd_val = queue_sel_reg;
      9'h034: rd_val = sel_valid ? QNM_W : 32'd0;
      9'h038: rd_val = {16'h0, sel_num};
      9'h044: rd_val = {31'h0, sel_ready};
      9'h060: rd_val = {30'h0, int_status_reg};
      9'h070: rd_val = {24'h0, status_reg};
      9'h080: rd_val = sel_desc;
      9'h090: rd_val = sel_avail;
      9'h0a0: rd_val = sel_used;
      default: rd_val = '0;
    endcase
  end

  // ---------------- global registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dev_feat_sel_reg <= '0;
      drv_feat_sel_reg <= '0;
      drv_features_reg <= '0;
      queue_sel_reg    <= '0;
      status_reg       <= '0;
      int_status_reg   <= '0;
      virtio_interrupt <= 1'b0;
      notify_valid     <= 1'b0;
      notify_queue     <= '0;
      dev_reset        <= 1'b0;
    end else begin
      dev_reset        <= status_clear;
      notify_valid     <= 1'b0;
      virtio_interrupt <= |int_status_reg;
      // A device reset drops pending interrupts, but an event arriving that cycle still lands.
      if (status_clear) int_status_reg <= irq_set;
      else              int_status_reg <= (int_status_reg & ~irq_ack) | irq_set;

      if (status_clear) begin
        status_reg       <= '0;
        dev_feat_sel_reg <= '0;
        drv_feat_sel_reg <= '0;
        queue_sel_reg    <= '0;
      end else if (wr_en) begin
        case (wr_off)
          9'h014: dev_feat_sel_reg <= wr_data;
          9'h020: begin
            if (drv_feat_sel_reg == 32'd0)      drv_features_reg[0] <= wr_data;
            else if (drv_feat_sel_reg == 32'd1) drv_features_reg[1] <= wr_data;
          end
          9'h024: drv_feat_sel_reg <= wr_data;
          9'h030: queue_sel_reg    <= wr_data;
          9'h050: begin
            if (wr_data < NQ_W) begin
              notify_valid <= 1'b1;
              notify_queue <= wr_data[3:0];
            end
          end
          9'h070: status_reg <= wr_data[7:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-queue registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_num_reg   <= '0;
      q_ready_reg <= '0;
      q_desc_reg  <= '0;
      q_avail_reg <= '0;
      q_used_reg  <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (status_clear) begin
          q_num_reg[i]   <= '0;
          q_ready_reg[i] <= 1'b0;
          q_desc_reg[i]  <= '0;
          q_avail_reg[i] <= '0;
          q_used_reg[i]  <= '0;
        end else if (wr_en && sel_hit[i]) begin
          case (wr_off)
            9'h038: if (wr_data <= QNM_W) q_num_reg[i] <= wr_data[15:0];
            9'h044: q_ready_reg[i] <= wr_data[0];
            9'h080: q_desc_reg[i]  <= wr_data;
            9'h090: q_avail_reg[i] <= wr_data;
            9'h0a0: q_used_reg[i]  <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
